// File: rtl/cmp_result_decoder.sv
// Consumes 13-bit comparator status words over valid/ready, drives E/G/L/- on a 7-seg display,
// and keeps saturating outcome counters. Define CMP_DEC_SEG_INV_EN for common-anode segments.
module cmp_result_decoder #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [12:0]      res_in,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             clr_stats,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [6:0]       seg_out,
  output logic             err,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt
);

`ifdef CMP_DEC_SEG_INV_EN
  localparam logic [6:0] SegMask = 7'b1111111;
`else
  localparam logic [6:0] SegMask = 7'b0000000;
`endif

  localparam logic [6:0] SegBlank = 7'b0000000 ^ SegMask;
  localparam logic [6:0] SegE     = 7'b1111001 ^ SegMask;
  localparam logic [6:0] SegG     = 7'b0111101 ^ SegMask;
  localparam logic [6:0] SegL     = 7'b0111000 ^ SegMask;
  localparam logic [6:0] SegDash  = 7'b1000000 ^ SegMask;

  localparam logic [7:0]       HoldInit = 8'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q;
  logic [7:0]       hold_q;
  logic [2:0]       flags_q;
  logic [6:0]       seg_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_eq_q, cnt_gt_q, cnt_lt_q;

  logic       accept;
  logic       legal;
  logic [6:0] seg_d;

  always_comb begin
    accept = res_valid && (state_q == StIdle);
    legal  = (res_in[12:3] == 10'd0) &&
             ((res_in[2:0] == 3'b001) || (res_in[2:0] == 3'b010) || (res_in[2:0] == 3'b100));
    seg_d  = SegDash;
    if (legal) begin
      unique case (res_in[2:0])
        3'b001:  seg_d = SegE;
        3'b010:  seg_d = SegG;
        default: seg_d = SegL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hold_q   <= 8'd0;
      flags_q  <= 3'b000;
      seg_q    <= SegBlank;
      err_q    <= 1'b0;
      cnt_eq_q <= '0;
      cnt_gt_q <= '0;
      cnt_lt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StHold;
            hold_q  <= HoldInit;
          end
        end
        StHold: begin
          if (hold_q == 8'd0) begin
            state_q <= StIdle;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (accept) begin
        seg_q <= seg_d;
        if (legal) begin
          flags_q <= res_in[2:0];
          if (res_in[0] && (cnt_eq_q != CntMax)) cnt_eq_q <= cnt_eq_q + CntOne;
          if (res_in[1] && (cnt_gt_q != CntMax)) cnt_gt_q <= cnt_gt_q + CntOne;
          if (res_in[2] && (cnt_lt_q != CntMax)) cnt_lt_q <= cnt_lt_q + CntOne;
        end else begin
          flags_q <= 3'b000;
          err_q   <= 1'b1;
        end
      end

      // Placed last so a clear on the accepting edge overrides the counter/err updates above.
      if (clr_stats) begin
        cnt_eq_q <= '0;
        cnt_gt_q <= '0;
        cnt_lt_q <= '0;
        err_q    <= 1'b0;
      end
    end
  end

  assign res_ready = (state_q == StIdle);
  assign eq        = flags_q[0];
  assign gt        = flags_q[1];
  assign lt        = flags_q[2];
  assign seg_out   = seg_q;
  assign err       = err_q;
  assign cnt_eq    = cnt_eq_q;
  assign cnt_gt    = cnt_gt_q;
  assign cnt_lt    = cnt_lt_q;

endmodule
